// File: rtl/pro_pkg.sv
// Shared widths, neutral pixel and FSM state type for the FCL sequencer.
package pro_pkg;

  localparam int unsigned PRO_WIDTH    = 8;
  localparam int unsigned PRO_PARALLEL = 4;
  localparam int unsigned ACC_WIDTH    = 16;
  localparam int unsigned PRO_CH_CNT   = 16;

  // Pixel value that contributes nothing to a PE accumulator for any weight.
  localparam logic [PRO_WIDTH-1:0] PRO_NEUTRAL_PIX = '0;

  typedef enum logic [2:0] {
    StIdle,
    StAcc,
    StDrain,
    StCapt,
    StOut
  } pro_state_e;

endpackage

// File: rtl/pro_fcl_capt.sv
// Result capture: registers PE results, binarizes them by sign and runs the
// output valid/ready handshake.
module pro_fcl_capt #(
  parameter int unsigned PRO_WIDTH    = pro_pkg::PRO_WIDTH,
  parameter int unsigned PRO_PARALLEL = pro_pkg::PRO_PARALLEL
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_capt,
  input  logic [PRO_PARALLEL*PRO_WIDTH-1:0] i_fcl_output,
  input  logic                              i_out_ready,
  output logic                              o_out_valid,
  output logic [PRO_PARALLEL*PRO_WIDTH-1:0] o_out_sum,
  output logic [PRO_PARALLEL-1:0]           o_out_bits,
  output logic                              o_done
);
  import pro_pkg::*;

  logic                              r_valid;
  logic                              r_done;
  logic [PRO_PARALLEL*PRO_WIDTH-1:0] r_sum;
  logic [PRO_PARALLEL-1:0]           r_bits;
  logic [PRO_PARALLEL-1:0]           w_bits;

  // Sign binarization: non-negative results map to 1.
  always_comb begin
    w_bits = '0;
    for (int i = 0; i < PRO_PARALLEL; i++) begin
      w_bits[i] = ~i_fcl_output[i*PRO_WIDTH + PRO_WIDTH - 1];
    end
  end

  // Capture on the CAPT cycle, hold until accepted, pulse done after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_bits  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_capt) begin
        r_sum   <= i_fcl_output;
        r_bits  <= w_bits;
        r_valid <= 1'b1;
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign o_out_valid = r_valid;
  assign o_out_sum   = r_sum;
  assign o_out_bits  = r_bits;
  assign o_done      = r_done;

endmodule

// File: rtl/pro_fcl_seq.sv
// FCL sequencer: streams one neuron group of pixel/weight beats into the PE
// array, drains the pipeline, then hands the captured results out.
module pro_fcl_seq #(
  parameter int unsigned PRO_WIDTH    = pro_pkg::PRO_WIDTH,
  parameter int unsigned PRO_PARALLEL = pro_pkg::PRO_PARALLEL,
  parameter int unsigned ACC_WIDTH    = pro_pkg::ACC_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_start,
  input  logic [15:0]                       i_n_pix,
  input  logic [$clog2(ACC_WIDTH)-1:0]      i_shift_cfg,
  input  logic                              i_in_valid,
  output logic                              o_in_ready,
  input  logic [PRO_WIDTH-1:0]              i_in_pix,
  input  logic [PRO_PARALLEL-1:0]           i_in_w,
  output logic [PRO_WIDTH-1:0]              o_fcl_input,
  output logic [PRO_PARALLEL-1:0]           o_fcl_w,
  output logic [$clog2(ACC_WIDTH)-1:0]      o_fcl_shift,
  output logic                              o_fcl_rst,
  input  logic [PRO_PARALLEL*PRO_WIDTH-1:0] i_fcl_output,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic [PRO_PARALLEL*PRO_WIDTH-1:0] o_out_sum,
  output logic [PRO_PARALLEL-1:0]           o_out_bits,
  output logic                              o_busy,
  output logic                              o_done
);
  import pro_pkg::*;

  localparam int unsigned SHIFT_W = $clog2(ACC_WIDTH);
  localparam logic [PRO_WIDTH-1:0] NEUTRAL_PIX = PRO_WIDTH'(PRO_NEUTRAL_PIX);

  pro_state_e             r_state;
  logic                   r_in_ready;
  logic [15:0]            r_cnt;
  logic [15:0]            r_n_pix;
  logic [SHIFT_W-1:0]     r_shift;
  logic [PRO_WIDTH-1:0]   r_fcl_input;
  logic [PRO_PARALLEL-1:0] r_fcl_w;
  logic                   r_fcl_rst;
  logic                   w_beat;
  logic                   w_capt;
  logic                   w_out_valid;

  assign w_beat = i_in_valid & r_in_ready;
  assign w_capt = (r_state == StCapt);

  // Sequencer FSM; PE drive signals default to a zero-contribution bubble and
  // are computed for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b0;
      r_cnt       <= '0;
      r_n_pix     <= '0;
      r_shift     <= '0;
      r_fcl_input <= NEUTRAL_PIX;
      r_fcl_w     <= '0;
      r_fcl_rst   <= 1'b0;
    end else begin
      r_fcl_input <= NEUTRAL_PIX;
      r_fcl_w     <= '1;
      r_fcl_rst   <= 1'b1;
      case (r_state)
        StIdle: begin
          if (i_start && (i_n_pix != 16'd0)) begin
            r_state    <= StAcc;
            r_n_pix    <= i_n_pix;
            r_shift    <= i_shift_cfg;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
          end else begin
            // Keep PE accumulators loading neutral data, i.e. cleared.
            r_fcl_w   <= '0;
            r_fcl_rst <= 1'b0;
          end
        end
        StAcc: begin
          if (w_beat) begin
            r_fcl_input <= i_in_pix;
            r_fcl_w     <= i_in_w;
            r_fcl_rst   <= (r_cnt != 16'd0);
            r_cnt       <= r_cnt + 16'd1;
            if (r_cnt == r_n_pix - 16'd1) begin
              r_state    <= StDrain;
              r_in_ready <= 1'b0;
            end
          end
        end
        StDrain: r_state <= StCapt;
        StCapt:  r_state <= StOut;
        StOut: begin
          if (w_out_valid && i_out_ready) begin
            r_state   <= StIdle;
            r_fcl_w   <= '0;
            r_fcl_rst <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  pro_fcl_capt #(
    .PRO_WIDTH    (PRO_WIDTH),
    .PRO_PARALLEL (PRO_PARALLEL)
  ) u_capt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_capt       (w_capt),
    .i_fcl_output (i_fcl_output),
    .i_out_ready  (i_out_ready),
    .o_out_valid  (w_out_valid),
    .o_out_sum    (o_out_sum),
    .o_out_bits   (o_out_bits),
    .o_done       (o_done)
  );

  assign o_in_ready  = r_in_ready;
  assign o_fcl_input = r_fcl_input;
  assign o_fcl_w     = r_fcl_w;
  assign o_fcl_shift = r_shift;
  assign o_fcl_rst   = r_fcl_rst;
  assign o_out_valid = w_out_valid;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_pro_fcl_seq.sv
// Bench for pro_fcl_seq with a behavioural PE array closing the loop.
module tb_pro_fcl_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] n_pix;
  logic [3:0]  shift_cfg;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pix;
  logic [3:0]  in_w;
  logic [7:0]  fcl_input;
  logic [3:0]  fcl_w;
  logic [3:0]  fcl_shift;
  logic        fcl_rst;
  logic [31:0] fcl_output;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [3:0]  out_bits;
  logic        busy;
  logic        done;

  int n_total;
  int n_pass;

  logic [7:0] g_pix [16];
  logic [3:0] g_w   [16];

  pro_fcl_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_n_pix      (n_pix),
    .i_shift_cfg  (shift_cfg),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_pix     (in_pix),
    .i_in_w       (in_w),
    .o_fcl_input  (fcl_input),
    .o_fcl_w      (fcl_w),
    .o_fcl_shift  (fcl_shift),
    .o_fcl_rst    (fcl_rst),
    .i_fcl_output (fcl_output),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_sum    (out_sum),
    .o_out_bits   (out_bits),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE array: weight 1 adds the pixel, weight 0 subtracts it.
  logic signed [15:0] pe_acc [4];

  function automatic logic signed [15:0] pe_term(input logic [7:0] p, input logic w);
    logic signed [15:0] s;
    s = 16'($signed(p));
    return w ? s : -s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) pe_acc[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pe_acc[i] <= fcl_rst ? pe_acc[i] + pe_term(fcl_input, fcl_w[i])
                             : pe_term(fcl_input, fcl_w[i]);
      end
    end
  end

  always_comb begin
    fcl_output = '0;
    for (int i = 0; i < 4; i++) fcl_output[i*8 +: 8] = 8'(pe_acc[i] >>> fcl_shift);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference result for the first n entries of g_pix/g_w.
  function automatic logic [31:0] exp_sum(input int n, input int sh);
    logic [31:0] r;
    int acc;
    int t;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      acc = 0;
      for (int b = 0; b < n; b++) begin
        t = int'($signed(g_pix[b]));
        acc += g_w[b][i] ? t : -t;
      end
      acc = acc >>> sh;
      r[i*8 +: 8] = acc[7:0];
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_bits(input logic [31:0] s);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ~s[i*8 + 7];
    return b;
  endfunction

  task automatic check_reset_vals();
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_in_ready", 32'(in_ready), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_out_sum", out_sum, 0);
    check_eq("rst_out_bits", 32'(out_bits), 0);
    check_eq("rst_fcl_w", 32'(fcl_w), 0);
    check_eq("rst_fcl_shift", 32'(fcl_shift), 0);
    check_eq("rst_fcl_rst", 32'(fcl_rst), 0);
    check_eq("rst_fcl_input", 32'(fcl_input), 0);
  endtask

  // One full group: start, beats (with optional bubbles), result, handshake.
  task automatic run_group(input int n, input int sh, input int bub_at, input int nbub,
                           input int rdy_wait, input bit hold_start,
                           input logic [31:0] es, input logic [3:0] eb);
    int edges;
    int beat;
    int bub_left;
    int done_cnt;
    bit hs;
    bit is_bub;
    start     = 1'b1;
    n_pix     = 16'(n);
    shift_cfg = 4'(sh);
    @(posedge clk); #1;
    start = hold_start;
    edges = 1;
    check_eq("busy_after_start", 32'(busy), 1);
    check_eq("fcl_shift", 32'(fcl_shift), 32'(sh));
    beat     = 0;
    bub_left = nbub;
    while (beat < n && edges < 300) begin
      is_bub = 1'b0;
      if (bub_left > 0 && beat == bub_at) begin
        in_valid = 1'b0;
        bub_left--;
        is_bub = 1'b1;
      end else begin
        in_valid = 1'b1;
        in_pix   = g_pix[beat];
        in_w     = g_w[beat];
      end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      edges++;
      if (hs) begin
        check_eq("beat_fcl_input", 32'(fcl_input), 32'(g_pix[beat]));
        check_eq("beat_fcl_w", 32'(fcl_w), 32'(g_w[beat]));
        check_eq("beat_fcl_rst", 32'(fcl_rst), (beat != 0) ? 1 : 0);
        beat++;
      end else if (is_bub) begin
        check_eq("bubble_fcl", {20'd0, fcl_rst, fcl_w, fcl_input[6:0]}, {20'd0, 1'b1, 4'hF, 7'd0});
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check_eq("in_ready_after_last", 32'(in_ready), 0);
    while (!out_valid && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq("out_valid_latency", edges, n + 3 + nbub);
    check_eq("out_sum", out_sum, es);
    check_eq("out_bits", 32'(out_bits), 32'(eb));
    done_cnt = 0;
    for (int k = 0; k < rdy_wait; k++) begin
      @(posedge clk); #1;
      done_cnt += int'(done);
      check_eq("hold_out_valid", 32'(out_valid), 1);
      check_eq("hold_out_sum", out_sum, es);
      check_eq("hold_out_bits", 32'(out_bits), 32'(eb));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    done_cnt += int'(done);
    check_eq("done_pulse", 32'(done), 1);
    check_eq("valid_dropped", 32'(out_valid), 0);
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("idle_fcl_rst", 32'(fcl_rst), 0);
    repeat (3) begin
      @(posedge clk); #1;
      done_cnt += int'(done);
    end
    check_eq("done_once", done_cnt, 1);
  endtask

  int seen;

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    n_pix     = '0;
    shift_cfg = '0;
    in_valid  = 1'b0;
    in_pix    = '0;
    in_w      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Neutral pixels: zero sums, all bits set, result at cycle 7.
    for (int b = 0; b < 4; b++) begin
      g_pix[b] = 8'd0;
      g_w[b]   = 4'(b + 1);
    end
    run_group(4, 0, 0, 0, 0, 1'b0, 32'h0, 4'hF);

    // Three beats, hand-computed: PE0/PE2 = 2, PE1/PE3 = -18.
    g_pix[0] = 8'd10;  g_w[0] = 4'b0101;
    g_pix[1] = 8'hFD;  g_w[1] = 4'b1111;
    g_pix[2] = 8'd5;   g_w[2] = 4'b0000;
    run_group(3, 0, 0, 0, 0, 1'b0, 32'hEE02EE02, 4'b0101);
    run_group(3, 0, 1, 2, 0, 1'b0, 32'hEE02EE02, 4'b0101);

    // Shifted result held for five cycles of back-pressure.
    g_pix[0] = 8'd100; g_w[0] = 4'b0011;
    g_pix[1] = 8'hEC;  g_w[1] = 4'b0110;
    run_group(2, 1, 0, 0, 5, 1'b0, 32'hD8C4283C, 4'b0011);

    // Reset at beat 2 of an 8-beat group.
    start = 1'b1; n_pix = 16'd8; shift_cfg = 4'd2;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1; in_pix = 8'd7; in_w = 4'hA;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      seen += int'(out_valid);
    end
    check_eq("no_valid_after_reset", seen, 0);
    check_eq("idle_after_reset", 32'(busy), 0);
    g_pix[0] = 8'hF6; g_w[0] = 4'b1001;
    run_group(1, 0, 0, 0, 0, 1'b0, 32'hF60A0AF6, 4'b0110);

    // Zero-length start is ignored.
    start = 1'b1; n_pix = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      check_eq("zero_npix_busy", 32'(busy), 0);
      check_eq("zero_npix_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end

    // Start held high while busy gives a single result.
    g_pix[0] = 8'd3; g_w[0] = 4'hF;
    g_pix[1] = 8'd4; g_w[1] = 4'hF;
    g_pix[2] = 8'd5; g_w[2] = 4'hF;
    run_group(3, 0, 0, 0, 0, 1'b1, 32'h0C0C0C0C, 4'hF);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      seen += int'(out_valid) + int'(busy);
    end
    check_eq("no_second_result", seen, 0);

    // Random groups against the reference model.
    repeat (3) begin
      for (int b = 0; b < 16; b++) begin
        g_pix[b] = 8'($urandom);
        g_w[b]   = 4'($urandom);
      end
      run_group(16, 4, 0, 0, 0, 1'b0, exp_sum(16, 4), exp_bits(exp_sum(16, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pro_fcl_seq.md
PRO_FCL_SEQ -- requirements
Module: pro_fcl_seq

Interface
REQ-001 Parameters: PRO_WIDTH, default 8, pixel/result width; PRO_PARALLEL, default 4, PE count; ACC_WIDTH, default 16, PE accumulator width.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  begin one neuron group; sampled only in IDLE.
REQ-005 n_pix  in  16  beats per group; latched at start.
REQ-006 shift_cfg  in  $clog2(ACC_WIDTH)  result right-shift; latched at start.
REQ-007 in_valid / in_ready  in / out  1  beat handshake.
REQ-008 in_pix  in  PRO_WIDTH  signed pixel; in_w  in  PRO_PARALLEL  one binary weight per PE.
REQ-009 fcl_input  out  PRO_WIDTH; fcl_w  out  PRO_PARALLEL; fcl_shift  out  $clog2(ACC_WIDTH); all registered.
REQ-010 fcl_rst  out  1  PE accumulate enable; low = load fresh, high = accumulate.
REQ-011 fcl_output  in  PRO_PARALLEL x PRO_WIDTH  PE results.
REQ-012 out_valid / out_ready  out / in  1  result handshake.
REQ-013 out_sum  out  PRO_PARALLEL x PRO_WIDTH  captured results; out_bits  out  PRO_PARALLEL  sign-binarized results.
REQ-014 busy  out  1  high outside IDLE; done  out  1  one-cycle pulse on result acceptance.

Function
REQ-015 FSM states: IDLE, ACC, DRAIN, CAPT, OUT.
REQ-016 IDLE->ACC on start with n_pix != 0; start with n_pix == 0 is ignored and the FSM stays in IDLE.
REQ-017 in_ready is high only in ACC while beats remain; beat counter counts accepted beats only.
REQ-018 Accepted beat at cycle t appears on fcl_input/fcl_w at t+1; the first beat of a group drives fcl_rst=0, later beats drive fcl_rst=1.
REQ-019 Bubble cycles in ACC, and all of DRAIN/CAPT/OUT: fcl_input=PRO_NEUTRAL_PIX, fcl_w all ones, fcl_rst=1, giving zero PE contribution.
REQ-020 In IDLE: fcl_rst=0, fcl_input=PRO_NEUTRAL_PIX, so PE accumulators hold a clear state.
REQ-021 ACC->DRAIN on acceptance of beat n_pix; DRAIN->CAPT after 1 cycle; in CAPT, out_sum <= fcl_output; CAPT->OUT.
REQ-022 out_bits[i] = 1 when out_sum[i] >= 0, else 0.
REQ-023 Without bubbles, out_valid rises exactly n_pix+3 cycles after the start-accept edge.
REQ-024 In OUT, out_valid stays high and out_sum/out_bits stay stable until out_ready; on handshake go to IDLE and pulse done.
REQ-025 fcl_shift = latched shift_cfg for the whole group; start is ignored while busy.

Reset
REQ-026 On rst low, at any time: state=IDLE, out_valid=0, in_ready=0, busy=0, done=0, out_sum=0, out_bits=0, fcl_w=0, fcl_shift=0, fcl_rst=0, fcl_input=PRO_NEUTRAL_PIX.
REQ-027 Reset mid-group discards the partial group; no out_valid follows.

Structure
REQ-028 Shared package pro_pkg holds PRO_WIDTH, PRO_PARALLEL, ACC_WIDTH, PRO_CH_CNT, PRO_NEUTRAL_PIX and the FSM state enum.
REQ-029 One sub-module, pro_fcl_capt, implements CAPT/OUT result registering, binarization and the output handshake.

Verification
REQ-030 n_pix=4, all beats in_pix=PRO_NEUTRAL_PIX, no bubbles -> out_sum all 0, out_bits=4'b1111, out_valid at cycle 7 after start.
REQ-031 n_pix=3 with 2 bubble cycles inserted -> same out_sum as without bubbles; out_valid 2 cycles later (cycle 8).
REQ-032 out_ready held low 5 cycles in OUT -> out_valid and out_sum stable for all 5; done pulses once on the handshake.
REQ-033 rst low at ACC beat 2 of n_pix=8 -> all outputs at reset values, no out_valid; a new start with n_pix=1 gives out_valid 4 cycles later.
REQ-034 start with n_pix=0 -> busy stays 0 and in_ready stays 0; start pulsed while busy -> ignored, single result produced.
REQ-035 Compare against a pro_fcl plus reference-model bench: random pixels/weights, n_pix=16, shift_cfg=4 -> out_sum and out_bits match the model exactly.
